// File: rtl/riscv_bus_pkg.sv
// Shared bus types for the RiscV data-side memory path: request payload,
// port identifiers and the read-mask encoding.
package riscv_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    localparam logic [3:0] WMASK_READ = 4'b0000;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [3:0]            wmask;
    } bus_req_t;

    function automatic logic is_read(input logic [3:0] wmask);
        return wmask == WMASK_READ;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request payload out from the
// requester, grant / stall / read return back to it.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wmask;
    logic              gnt;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output req, lock, addr, wdata, wmask,
        input  gnt, stall, rdata, rvalid
    );

    modport slave (
        input  req, lock, addr, wdata, wmask,
        output gnt, stall, rdata, rvalid
    );
endinterface

// File: rtl/rr_arb2_lock.sv
// Two-way round-robin arbiter (CPU vs host) with a bounded host lock.
// state   | meaning
// LK_OPEN | no lock, plain round-robin between the two ports
// LK_HELD | host holds the bus while it keeps requesting, up to LOCK_MAX grants
module rr_arb2_lock
    import riscv_bus_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req_i,
    input  logic dbg_req_i,
    input  logic dbg_lock_i,
    output logic cpu_gnt_o,
    output logic dbg_gnt_o
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    localparam logic [0:0] LK_OPEN = 1'b0;
    localparam logic [0:0] LK_HELD = 1'b1;

    logic [0:0]       lk_state_q, lk_state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    port_e            last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             lock_active;

    assign lock_active = (lk_state_q == LK_HELD);
    assign cnt_inc     = lock_cnt_q + CNT_W'(1);

    always_comb begin
        cpu_gnt_o = 1'b0;
        dbg_gnt_o = 1'b0;
        if (!reset) begin
            if (lock_active && dbg_req_i) begin
                dbg_gnt_o = 1'b1;
            end else if (cpu_req_i && dbg_req_i) begin
                if (last_grant_q == PORT_DBG) begin
                    cpu_gnt_o = 1'b1;
                end else begin
                    dbg_gnt_o = 1'b1;
                end
            end else begin
                cpu_gnt_o = cpu_req_i;
                dbg_gnt_o = dbg_req_i;
            end
        end
    end

    always_comb begin
        lk_state_d   = lk_state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        if (cpu_gnt_o) begin
            last_grant_d = PORT_CPU;
        end
        if (dbg_gnt_o) begin
            last_grant_d = PORT_DBG;
            if (dbg_lock_i && (cnt_inc != CNT_W'(LOCK_MAX))) begin
                lk_state_d = LK_HELD;
                lock_cnt_d = cnt_inc;
            end else begin
                // Forced release keeps last_grant = DBG so a waiting CPU wins next.
                lk_state_d = LK_OPEN;
                lock_cnt_d = '0;
            end
        end else if (lock_active && !dbg_req_i) begin
            lk_state_d = LK_OPEN;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lk_state_q   <= LK_OPEN;
            lock_cnt_q   <= '0;
            last_grant_q <= PORT_DBG;
        end else begin
            lk_state_q   <= lk_state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and the
// host/debug port; muxes the granted request and steers read data back.
module dmem_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dbg,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] RSEL_NONE = 2'd0;
    localparam logic [1:0] RSEL_CPU  = 2'd1;
    localparam logic [1:0] RSEL_DBG  = 2'd2;

    logic              cpu_gnt, dbg_gnt;
    bus_req_t          cpu_bus, dbg_bus, sel_bus;
    logic [1:0]        rsel_q, rsel_d;
    logic              cpu_rvalid, dbg_rvalid;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              unused_cpu_lock;

    // The CPU never locks the bus; its lock line exists only for port symmetry.
    assign unused_cpu_lock = cpu.lock;

    rr_arb2_lock #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .cpu_req_i  (cpu.req),
        .dbg_req_i  (dbg.req),
        .dbg_lock_i (dbg.lock),
        .cpu_gnt_o  (cpu_gnt),
        .dbg_gnt_o  (dbg_gnt)
    );

    always_comb begin
        cpu_bus.addr  = BUS_ADDR_W'(cpu.addr);
        cpu_bus.wdata = BUS_DATA_W'(cpu.wdata);
        cpu_bus.wmask = cpu.wmask;
        dbg_bus.addr  = BUS_ADDR_W'(dbg.addr);
        dbg_bus.wdata = BUS_DATA_W'(dbg.wdata);
        dbg_bus.wmask = dbg.wmask;
    end

    always_comb begin
        sel_bus = '0;
        if (cpu_gnt) begin
            sel_bus = cpu_bus;
        end else if (dbg_gnt) begin
            sel_bus = dbg_bus;
        end
    end

    assign mem_en    = cpu_gnt | dbg_gnt;
    assign mem_addr  = ADDR_W'(sel_bus.addr);
    assign mem_wdata = DATA_W'(sel_bus.wdata);
    assign mem_wmask = sel_bus.wmask;

    assign cpu.gnt   = cpu_gnt;
    assign dbg.gnt   = dbg_gnt;
    assign cpu.stall = cpu.req & ~cpu_gnt;
    assign dbg.stall = dbg.req & ~dbg_gnt;

    always_comb begin
        rsel_d = RSEL_NONE;
        if (cpu_gnt && is_read(cpu.wmask)) begin
            rsel_d = RSEL_CPU;
        end else if (dbg_gnt && is_read(dbg.wmask)) begin
            rsel_d = RSEL_DBG;
        end
    end

    // Gating with reset drops an in-flight return in the cycle reset is raised.
    assign cpu_rvalid = (rsel_q == RSEL_CPU) & ~reset;
    assign dbg_rvalid = (rsel_q == RSEL_DBG) & ~reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

    assign cpu.rvalid = cpu_rvalid;
    assign dbg.rvalid = dbg_rvalid;
    assign cpu.rdata  = cpu_rdata;
    assign dbg.rdata  = dbg_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsel_q      <= RSEL_NONE;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            rsel_q      <= rsel_d;
            cpu_rdata_q <= cpu_rdata;
            dbg_rdata_q <= dbg_rdata;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port between the CPU load/store path and a debug/host port.
- Arbitrates per access with 2-way round-robin.
- Returns read data one cycle after grant, with a per-port valid.
- Stalls the CPU while it is not granted.
- Supports a bounded host "lock" for atomic multi-access sequences.

Sits between the RiscV core data side and the data RAM / memory-mapped LED decode.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
LOCK_MAX, 8, maximum consecutive locked host grants before a forced release

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU write data
cpu_wmask  in  4  CPU byte write mask; 0 = read
cpu_gnt  out  1  CPU access issued this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid
dbg_req  in  1  host access request
dbg_lock  in  1  host requests that the bus be kept after this grant
dbg_addr  in  ADDR_W  host byte address
dbg_wdata  in  DATA_W  host write data
dbg_wmask  in  4  host byte write mask; 0 = read
dbg_gnt  out  1  host access issued this cycle
dbg_rdata  out  DATA_W  host read data
dbg_rvalid  out  1  dbg_rdata valid
mem_en  out  1  memory access strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  4  memory byte write mask
mem_rdata  in  DATA_W  memory read data, synchronous, 1-cycle latency

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - last_grant = DBG, so the CPU wins the first tie.
  - lock_active = 0, lock_cnt = 0.
  - rvalid_sel = none; cpu_rvalid = dbg_rvalid = 0.
  - While reset is high: cpu_gnt = dbg_gnt = mem_en = 0, mem_wmask = 0, cpu_stall = cpu_req.
- Grant is combinational in the request cycle:
  - Single requester: that requester is granted.
  - Both requesting, no lock: grant the port that is not last_grant.
  - lock_active and dbg_req: DBG granted regardless of cpu_req.
  - No request: mem_en = 0, mem_addr/wdata = 0, mem_wmask = 0.
- Mux: mem_en = any grant. mem_addr, mem_wdata and mem_wmask come from the granted port.
- Requester handshake:
  - Requester holds req, addr, wdata and wmask stable until it sees gnt.
  - One access per grant cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- Read return:
  - The cycle after a grant with wmask == 0, the port's rvalid = 1 and its rdata = mem_rdata.
  - Other port's rdata holds its last value with rvalid = 0.
  - Writes produce no rvalid.
- Arbiter state:
  - last_grant updates on every grant.
  - lock_active sets when DBG is granted with dbg_lock = 1.
  - lock_cnt increments on each locked DBG grant.
- Lock release, first of:
  - DBG granted with dbg_lock = 0;
  - dbg_req = 0 while lock_active;
  - lock_cnt reaches LOCK_MAX. On this forced release, last_grant = DBG, so a waiting CPU wins the next cycle.
  - On any release, lock_cnt returns to 0. Relock is possible only after the next DBG grant.
- Starvation bound: CPU wait ≤ LOCK_MAX + 1 cycles.
- cpu_stall = cpu_req & ~cpu_gnt; it feeds the core's PC/regfile write-enable hold.
- Reset mid-access: a pending rvalid is dropped (0 the cycle after reset asserts) and lock is cleared.

Decomposition:
- Package riscv_bus_pkg holds:
  - typedef bus_req_t struct: addr, wdata, wmask;
  - enum port_e {PORT_CPU, PORT_DBG};
  - constant WMASK_READ = 4'b0000.
- One sub-module, rr_arb2_lock: holds last_grant, lock_active and lock_cnt, and produces the grant vector. The top level does the mux and the read-return steering.

Test Plan:
- CPU only: cpu_req=1, addr 0x36, wmask 0 → cpu_gnt same cycle, mem_addr 0x36; next cycle cpu_rvalid=1 with mem_rdata; dbg_rvalid=0.
- Tie after reset: both request, CPU write 0x10, host read 0x20 → cycle0 CPU granted (stall=0), cycle1 DBG granted, cycle2 dbg_rvalid=1; cpu_stall=0 throughout after cycle0.
- Alternation: both request continuously for 6 cycles → grants C,D,C,D,C,D; each read's rvalid lands on the correct port one cycle later.
- Lock timeout, LOCK_MAX=8: dbg_lock=1, dbg_req=1, cpu_req=1 held → 8 consecutive DBG grants with cpu_stall=1, then the CPU is granted on cycle 9.
- Lock release early: lock with 3 grants, then dbg_lock=0 on the 4th → the next tie grants CPU; lock_cnt back to 0.
- Reset mid-read: DBG read granted, reset asserted the next cycle → dbg_rvalid=0, all grants 0; after release a tie grants CPU first.
